// File: rtl/hyp_cordic_pkg.sv
// Shared Q2.14 constants, FSM state type and saturation helper for the
// hyperbolic CORDIC rotator and its post-processing stages.
package hyp_cordic_pkg;

   localparam int W    = 16;
   localparam int FRAC = 14;

   localparam logic [W-1:0] ONE     = 16'h4000;
   localparam logic [W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [W-1:0] SAT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   // Clamp a sign-extended wide value into the signed Q2.14 range.
   function automatic logic [W-1:0] sat_w(input logic signed [31:0] v);
      logic [W-1:0] r;
      if (v > 32'sh0000_7FFF) begin
         r = SAT_MAX;
      end else if (v < 32'shFFFF_8000) begin
         r = SAT_MIN;
      end else begin
         r = v[W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/lin_cordic_step.sv
// One linear-mode vectoring CORDIC iteration: drives y towards zero while
// accumulating the quotient in z with weight ONE >> i.
module lin_cordic_step
   import hyp_cordic_pkg::*;
#(
   parameter int AW = 18,
   parameter int IW = 4
) (
   input  logic signed [AW-1:0] x,
   input  logic signed [AW-1:0] y,
   input  logic signed [AW-1:0] z,
   input  logic        [IW-1:0] i,
   output logic signed [AW-1:0] y_nxt,
   output logic signed [AW-1:0] z_nxt
);

   logic signed [AW-1:0] x_sh_s;
   logic        [AW-1:0] wt_s;

   // Rotate towards y = 0 by the shifted divisor, steering z the same way.
   always_comb begin
      x_sh_s = x >>> i;
      wt_s   = {{(AW-W){1'b0}}, ONE} >> i;
      y_nxt  = y;
      z_nxt  = z;
      if (y[AW-1]) begin
         y_nxt = y + x_sh_s;
         z_nxt = z - wt_s;
      end else begin
         y_nxt = y - x_sh_s;
         z_nxt = z + wt_s;
      end
   end

endmodule

// File: rtl/hyp_tanh_exp_post.sv
// Post-processor for the hyperbolic rotator: tanh = sinh/cosh via an
// iterative linear CORDIC divider, exp = cosh + sinh via one saturating add.
module hyp_tanh_exp_post
   import hyp_cordic_pkg::*;
#(
   parameter int W = hyp_cordic_pkg::W,
   parameter int N = 15,
   parameter int G = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         st,
   input  logic [W-1:0] sinh_in,
   input  logic [W-1:0] cosh_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] tanh_out,
   output logic [W-1:0] exp_out,
   output logic         exp_ovf,
   output logic         div_err
);

   localparam int AW = W + G;
   localparam int IW = $clog2(N + 1);

   state_e               state_q, state_d;
   logic signed [AW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic        [IW-1:0] i_q, i_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic        [W-1:0]  tanh_q, tanh_d, exp_q, exp_d;
   logic                 ovf_q, ovf_d, derr_q, derr_d;

   logic signed [W:0]    exp_sum_s;
   logic                 cosh_pos_s;
   logic signed [AW-1:0] y_step_s, z_step_s;

   lin_cordic_step #(.AW(AW), .IW(IW)) u_step (
      .x     (x_q),
      .y     (y_q),
      .z     (z_q),
      .i     (i_q),
      .y_nxt (y_step_s),
      .z_nxt (z_step_s)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= {AW{1'b0}};
         y_q     <= {AW{1'b0}};
         z_q     <= {AW{1'b0}};
         i_q     <= {IW{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tanh_q  <= {W{1'b0}};
         exp_q   <= {W{1'b0}};
         ovf_q   <= 1'b0;
         derr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tanh_q  <= tanh_d;
         exp_q   <= exp_d;
         ovf_q   <= ovf_d;
         derr_q  <= derr_d;
      end
   end

   // Next-state and datapath update; exp is resolved on the accepting edge.
   always_comb begin
      exp_sum_s  = {sinh_in[W-1], sinh_in} + {cosh_in[W-1], cosh_in};
      cosh_pos_s = !cosh_in[W-1] && (cosh_in != {W{1'b0}});
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      i_d        = i_q;
      tanh_d     = tanh_q;
      exp_d      = exp_q;
      ovf_d      = ovf_q;
      derr_d     = derr_q;
      case (state_q)
         IDLE: begin
            if (st) begin
               x_d   = {{G{cosh_in[W-1]}}, cosh_in};
               y_d   = {{G{sinh_in[W-1]}}, sinh_in};
               z_d   = {AW{1'b0}};
               i_d   = {IW{1'b0}};
               exp_d = sat_w(32'(exp_sum_s));
               ovf_d = exp_sum_s[W] ^ exp_sum_s[W-1];
               if (cosh_pos_s) begin
                  derr_d  = 1'b0;
                  state_d = CALC;
               end else begin
                  derr_d  = 1'b1;
                  tanh_d  = {W{1'b0}};
                  state_d = FIN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            y_d = y_step_s;
            z_d = z_step_s;
            i_d = i_q + {{(IW-1){1'b0}}, 1'b1};
            if (i_q == IW'(N - 1)) begin
               state_d = FIN;
            end else begin
               state_d = CALC;
            end
         end
         FIN: begin
            tanh_d  = sat_w(32'(z_q));
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status flags, registered so they align with the state they describe.
   always_comb begin
      busy_d = (state_d == CALC);
      done_d = (state_q == FIN);
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign tanh_out = tanh_q;
   assign exp_out  = exp_q;
   assign exp_ovf  = ovf_q;
   assign div_err  = derr_q;

endmodule

// File: tb/tb_hyp_tanh_exp_post.sv
// Scoreboard bench for hyp_tanh_exp_post: the driver pushes hand-computed
// results, a negedge monitor pops and compares on every done pulse.
module tb_hyp_tanh_exp_post;

   localparam int N = 15;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st = 1'b0;
   logic [15:0] sinh_in = 16'h0000;
   logic [15:0] cosh_in = 16'h0000;
   logic        busy, done, exp_ovf, div_err;
   logic [15:0] tanh_out, exp_out;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      int          tanh;
      logic [15:0] expv;
      logic        ovf;
      logic        derr;
      int          due;
   } exp_t;

   exp_t sb[$];

   hyp_tanh_exp_post dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .st       (st),
      .sinh_in  (sinh_in),
      .cosh_in  (cosh_in),
      .busy     (busy),
      .done     (done),
      .tanh_out (tanh_out),
      .exp_out  (exp_out),
      .exp_ovf  (exp_ovf),
      .div_err  (div_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic chk_tol(input string nm, input int act, input int req, input int tol);
      n_checks++;
      if (act > req + tol || act < req - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d +/-%0d (cycle %0d)", nm, act, req, tol, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk_tol("tanh_out", int'($signed(tanh_out)), e.tanh, 2);
            chk("exp_out", int'(exp_out), int'(e.expv));
            chk("exp_ovf", int'(exp_ovf), int'(e.ovf));
            chk("div_err", int'(div_err), int'(e.derr));
            chk("done_cycle", cyc, e.due);
         end
      end
   end

   // Start an operation with a one-cycle st pulse and queue its expected result.
   task automatic start_op(input logic [15:0] s, input logic [15:0] c, input int tanh_e,
                           input logic [15:0] exp_e, input logic ovf_e, input logic derr_e);
      exp_t e;
      @(negedge clk);
      sinh_in = s;
      cosh_in = c;
      st      = 1'b1;
      @(negedge clk);
      st = 1'b0;
      e.tanh = tanh_e;
      e.expv = exp_e;
      e.ovf  = ovf_e;
      e.derr = derr_e;
      e.due  = cyc + (derr_e ? 1 : N + 1);
      sb.push_back(e);
      chk("busy_at_start", int'(busy), derr_e ? 0 : 1);
      chk("exp_out_at_start", int'(exp_out), int'(exp_e));
      chk("div_err_at_start", int'(div_err), int'(derr_e));
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: %0d results still pending, expected 0", sb.size());
         sb.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tanh", int'(tanh_out), 0);
      chk("rst_exp", int'(exp_out), 0);
      chk("rst_ovf", int'(exp_ovf), 0);
      chk("rst_derr", int'(div_err), 0);
      rst_n = 1'b1;

      // Basic quotients in range.
      start_op(16'h0000, 16'h4000, 0, 16'h4000, 1'b0, 1'b0);
      drain();
      start_op(16'h2000, 16'h4000, 8192, 16'h6000, 1'b0, 1'b0);
      drain();
      start_op(16'hE000, 16'h4000, -8192, 16'h2000, 1'b0, 1'b0);
      drain();
      // 19210/25304*16384 = 12438.2; exp sum 0xADE2 overflows positive.
      start_op(16'h4B0A, 16'h62D8, 12438, 16'h7FFF, 1'b1, 1'b0);
      drain();
      // Quotient ~4 is out of range: saturates to the full z weight sum.
      start_op(16'h7FFF, 16'h2000, 32767, 16'h7FFF, 1'b1, 1'b0);
      drain();

      // Divide errors, then a valid op clears div_err.
      start_op(16'h1234, 16'h0000, 0, 16'h1234, 1'b0, 1'b1);
      drain();
      start_op(16'h8000, 16'hC000, 0, 16'h8000, 1'b1, 1'b1);
      drain();
      start_op(16'h1000, 16'h4000, 4096, 16'h5000, 1'b0, 1'b0);
      drain();

      // st during CALC is ignored and not queued.
      start_op(16'hF000, 16'h4000, -4096, 16'h3000, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      sinh_in = 16'h3000;
      cosh_in = 16'h3000;
      st      = 1'b1;
      @(negedge clk);
      st = 1'b0;
      drain();
      repeat (20) @(negedge clk);

      // st held high: back-to-back operations, second accepted right after FIN.
      begin
         exp_t e;
         @(negedge clk);
         sinh_in = 16'hC000;
         cosh_in = 16'h4000;
         st      = 1'b1;
         @(negedge clk);
         e.tanh = -16384;
         e.expv = 16'h0000;
         e.ovf  = 1'b0;
         e.derr = 1'b0;
         e.due  = cyc + N + 1;
         sb.push_back(e);
         e.due  = cyc + 2 * (N + 2) - 1;
         sb.push_back(e);
         repeat (N + 2) @(negedge clk);
         chk("busy_second_op", int'(busy), 1);
         st = 1'b0;
         drain();
      end

      // Asynchronous reset during iteration 7 aborts without a done pulse.
      start_op(16'h2000, 16'h4000, 8192, 16'h6000, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      sb.delete();
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_tanh", int'(tanh_out), 0);
      chk("abort_exp", int'(exp_out), 0);
      chk("abort_ovf", int'(exp_ovf), 0);
      chk("abort_derr", int'(div_err), 0);
      repeat (2) @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      rst_n = 1'b1;
      start_op(16'h2000, 16'h4000, 8192, 16'h6000, 1'b0, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
